fetch_decode_ctrl: RTL

IF/ID pipeline register and front-end hazard/redirect controller for the 5-stage MIPS core. It sits directly downstream of program memory fetch and consumes its `ins` and `current_address`. It drives fetch's `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc`, detects load-use hazards and J/JAL jumps, accepts taken-branch redirects from EX, and presents the decoded-stage instruction to the register file and control unit.

---
 rtl/fetch_decode_ctrl_if.sv | 13 +
 rtl/fetch_decode_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if: fetch <-> IF/ID controller bundle (ins/current_address from fetch; stall/stall_pm/pc_mux_sel/jmp_loc to fetch)
interface fetch_decode_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic [31:0]       ins;
   logic [ADDR_W-1:0] current_address;
   logic              stall;
   logic              stall_pm;
   logic              pc_mux_sel;
   logic [ADDR_W-1:0] jmp_loc;
   modport master (output ins, current_address, input stall, stall_pm, pc_mux_sel, jmp_loc);
   modport slave  (input ins, current_address, output stall, stall_pm, pc_mux_sel, jmp_loc);
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: IF/ID register with load-use stall, J/JAL and EX branch redirect control; ports: clk, reset (sync, active high), fif (fetch bundle, slave), ex_branch_taken/ex_branch_target (EX redirect), id_ins/id_pc/id_valid (ID stage), stall_count (saturating hazard bubble count)
module fetch_decode_ctrl #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int ADDR_W          = 16
) (
   input  logic                clk,
   input  logic                reset,
   fetch_decode_ctrl_if.slave  fif,
   input  logic                ex_branch_taken,
   input  logic [ADDR_W-1:0]   ex_branch_target,
   output logic [31:0]         id_ins,
   output logic [ADDR_W-1:0]   id_pc,
   output logic                id_valid,
   output logic [15:0]         stall_count
);
   typedef enum logic {RUN, STALL} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [31:0]       id_ins_q, id_ins_d;
   logic              id_valid_q, id_valid_d;
   logic [15:0]       stall_count_q, stall_count_d;
   logic              uses_rt, hazard, jump, stall, bubble;
   always_comb begin
      uses_rt       = fif.ins[31:26] inside {6'b000000, 6'b000100, 6'b000101, 6'b101011};
      hazard        = state_q == RUN && id_valid_q && id_ins_q[31:26] == 6'b100011 && id_ins_q[20:16] != 5'd0 &&
                      (fif.ins[25:21] == id_ins_q[20:16] || (uses_rt && fif.ins[20:16] == id_ins_q[20:16]));
      // J (000010) and JAL (000011) share op[31:27]
      jump          = state_q == RUN && id_valid_q && id_ins_q[31:27] == 5'b00001;
      stall         = !ex_branch_taken && (hazard || state_q == STALL);
      bubble        = ex_branch_taken || stall || jump;
      id_ins_d      = bubble ? 32'd0 : fif.ins;
      id_pc_d       = bubble ? id_pc_q : fetch_pc_q;
      id_valid_d    = !bubble;
      stall_count_d = stall_count_q + 16'(stall && stall_count_q != 16'hFFFF);
      cnt_d         = ex_branch_taken ? 3'd0 : state_q == STALL ? cnt_q - 3'd1 : hazard ? 3'(LOAD_USE_CYCLES - 1) : cnt_q;
      // STALL exits on the edge where the remaining count reaches zero
      state_d       = ex_branch_taken ? RUN : state_q == STALL ? (cnt_q <= 3'd1 ? RUN : STALL) :
                      (hazard && LOAD_USE_CYCLES > 1) ? STALL : RUN;
      fif.stall      = stall;
      fif.stall_pm   = stall;
      fif.pc_mux_sel = ex_branch_taken || jump;
      fif.jmp_loc    = ex_branch_taken ? ex_branch_target : jump ? ADDR_W'(id_ins_q[15:0]) : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         cnt_q         <= 3'd0;
         fetch_pc_q    <= '0;
         id_ins_q      <= 32'd0;
         id_pc_q       <= '0;
         id_valid_q    <= 1'b0;
         stall_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fetch_pc_q    <= fif.current_address;
         id_ins_q      <= id_ins_d;
         id_pc_q       <= id_pc_d;
         id_valid_q    <= id_valid_d;
         stall_count_q <= stall_count_d;
      end
   end
   assign id_ins      = id_ins_q;
   assign id_pc       = id_pc_q;
   assign id_valid    = id_valid_q;
   assign stall_count = stall_count_q;
endmodule
